pipe_stall_ctrl: RTL and testbench
==================================

// Module: pipe_stall_ctrl
// PURPOSE
//  Central hazard/exception sequencer for the 5-stage pipeline. Merges per-stage stall requests
//  into the 6-bit stall vector (bit0=PC,1=IF,2=ID,3=EX,4=MEM,5=WB; 1=Stop) used by every
//  pipeline register. Sequences precise exceptions: bubble into WB, then a one-cycle flush with redirect PC.
//  Counts stall cycles for profiling.
// PARAMETERS
//  EXC_BASE     32'h0000_0020  handler entry PC for all non-ERET exceptions
//  WDOG_LIMIT   16'd1024       consecutive-stall cycles before watchdog trip (STALL_WDOG_EN only)
// PORTS
//  clk           in   1   clock; all state updates on posedge
//  rst           in   1   asynchronous, active-high reset
//  stallreq_if   in   1   instruction fetch not ready
//  stallreq_id   in   1   load-use hazard
//  stallreq_ex   in   1   multi-cycle EX op busy
//  stallreq_mem  in   1   data memory not ready
//  exc_valid     in   1   MEM-stage instruction raised exception (level, sampled each cycle)
//  exc_eret      in   1   qualifies exc_valid: exception is ERET
//  epc_i         in   32  return PC for ERET
//  stall         out  6   stall vector to all pipeline registers
//  flush         out  1   clear all pipeline registers this cycle
//  new_pc        out  32  redirect PC, valid while flush=1
//  stall_cnt     out  32  total cycles with stall!=0 (wraps)
//  wdog_err      out  1   sticky watchdog trip (0 when STALL_WDOG_EN undefined)
// BEHAVIOUR
//  Reset (async): state=RUN; flush=0, new_pc=0, stall_cnt=0, wdog_err=0, run counter=0; stall=0.
//  FSM states: RUN, FLUSH.
//  RUN, stall is combinational from inputs, priority exc > mem > ex > id > if:
//   exc_valid -> 6'b011111 (freeze PC..MEM, bubble WB so faulting insn never commits); next FLUSH;
//     latch new_pc <= exc_eret ? epc_i : EXC_BASE
//   stallreq_mem -> 6'b011111; stallreq_ex -> 6'b001111; stallreq_id -> 6'b000111;
//   stallreq_if -> 6'b000011; none -> 6'b000000
//  FLUSH (exactly 1 cycle): flush=1, stall=6'b000000, new_pc holds latched value; all stall
//   requests and exc_valid ignored; next RUN. flush=0 in every RUN cycle.
//  new_pc retains last latched value outside FLUSH; only meaningful when flush=1.
//  Exception-to-redirect latency: 1 cycle (detect cycle, then FLUSH cycle).
//  Back-to-back: exc_valid high in the first RUN cycle after FLUSH is a new exception.
//  stall_cnt: +1 on each posedge where stall!=0; 32'hFFFF_FFFF wraps to 0. FLUSH cycles
//   do not count.
//  Reset mid-FLUSH: immediately RUN, flush=0, latched PC cleared.
// CONFIGURATION
//  STALL_WDOG_EN defined: 16-bit run counter +1 each cycle with stall!=0, cleared to 0
//   on any cycle with stall==0 or in FLUSH; when counter reaches WDOG_LIMIT, wdog_err
//   set (sticky until rst); counter saturates at WDOG_LIMIT. Pipeline behaviour unchanged.
//  STALL_WDOG_EN undefined: no counter logic; wdog_err tied 0.
// STRUCTURE
//  Shared defines header: Stop/NotStop, RstEnable, stall encodings (STALL_MEM/EX/ID/IF/NONE),
//   FSM state codes, ZeroWord, EXC_BASE default.
//  One sub-module: stall_wdog (run counter + sticky flag), instantiated only under STALL_WDOG_EN.
//  Priority encoder and FSM stay in the top module.
// TESTING
//  1 stallreq_id=1 and stallreq_if=1, same cycle -> stall=6'b000111; stall_cnt +1 per cycle held.
//  2 stallreq_ex=1 for 3 cycles, then 0 -> stall=6'b001111 x3, then 6'b000000; stall_cnt=3.
//  3 exc_valid=1, exc_eret=0, stallreq_mem=1 -> stall=6'b011111; next cycle flush=1,
//    new_pc=32'h20, stall=0; following cycle flush=0.
//  4 exc_valid=1, exc_eret=1, epc_i=32'h0000_1234 -> next cycle flush=1, new_pc=32'h1234;
//    exc_valid held during FLUSH has no effect.
//  5 Assert rst asynchronously during FLUSH -> flush=0, new_pc=0, stall_cnt=0 before next edge.
//  6 STALL_WDOG_EN, WDOG_LIMIT=4: stallreq_mem held 4 cycles -> wdog_err=1 after 4th edge,
//    stays 1 after request drops; undefined build -> wdog_err=0 throughout.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants, stall encodings and FSM state type for the pipeline stall/exception sequencer.
package pipe_stall_ctrl_pkg;

    localparam int unsigned STALL_W = 6;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned WDOG_W  = 16;

    localparam logic STOP       = 1'b1;
    localparam logic NOT_STOP   = 1'b0;
    localparam logic RST_ENABLE = 1'b1;

    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;

    localparam logic [WORD_W-1:0] ZERO_WORD        = 32'h0000_0000;
    localparam logic [WORD_W-1:0] EXC_BASE_DEFAULT = 32'h0000_0020;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/pipe_stall_ctrl_wdog.sv
// Consecutive-stall run counter with a sticky trip flag; only built when STALL_WDOG_EN is defined.
module stall_wdog
    import pipe_stall_ctrl_pkg::*;
#(
    parameter logic [WDOG_W-1:0] LIMIT = 16'd1024
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_active,
    output logic wdog_err
);

    logic [WDOG_W-1:0] run_cnt;
    logic [WDOG_W-1:0] run_nxt_c;

    // Saturate at the limit so a long stall cannot wrap the counter.
    always_comb begin
        run_nxt_c = (run_cnt >= LIMIT) ? LIMIT : run_cnt + WDOG_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            run_cnt  <= '0;
            wdog_err <= 1'b0;
        end else if (stall_active) begin
            run_cnt <= run_nxt_c;
            if (run_nxt_c >= LIMIT) begin
                wdog_err <= 1'b1;
            end
        end else begin
            run_cnt <= '0;
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall-vector priority merge, precise-exception flush sequencer and stall profiling counter.
// Optional watchdog on consecutive stall cycles is enabled by defining STALL_WDOG_EN.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter logic [WORD_W-1:0] EXC_BASE   = EXC_BASE_DEFAULT,
    parameter logic [WDOG_W-1:0] WDOG_LIMIT = 16'd1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_if,
    input  logic                stallreq_id,
    input  logic                stallreq_ex,
    input  logic                stallreq_mem,
    input  logic                exc_valid,
    input  logic                exc_eret,
    input  logic [WORD_W-1:0]   epc_i,
    output logic [STALL_W-1:0]  stall,
    output logic                flush,
    output logic [WORD_W-1:0]   new_pc,
    output logic [WORD_W-1:0]   stall_cnt,
    output logic                wdog_err
);

    state_e state;

    // Exception outranks all requests; WB is bubbled so the faulting instruction never commits.
    always_comb begin
        stall = STALL_NONE;
        if (state == ST_RUN) begin
            if (exc_valid)         stall = STALL_MEM;
            else if (stallreq_mem) stall = STALL_MEM;
            else if (stallreq_ex)  stall = STALL_EX;
            else if (stallreq_id)  stall = STALL_ID;
            else if (stallreq_if)  stall = STALL_IF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state     <= ST_RUN;
            flush     <= 1'b0;
            new_pc    <= ZERO_WORD;
            stall_cnt <= ZERO_WORD;
        end else begin
            if (stall != STALL_NONE) begin
                stall_cnt <= stall_cnt + WORD_W'(1);
            end
            case (state)
                ST_RUN: begin
                    flush <= 1'b0;
                    if (exc_valid) begin
                        state  <= ST_FLUSH;
                        flush  <= 1'b1;
                        new_pc <= exc_eret ? epc_i : EXC_BASE;
                    end
                end
                ST_FLUSH: begin
                    state <= ST_RUN;
                    flush <= 1'b0;
                end
                default: begin
                    state <= ST_RUN;
                    flush <= 1'b0;
                end
            endcase
        end
    end

`ifdef STALL_WDOG_EN
    stall_wdog #(
        .LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk          (clk),
        .rst          (rst),
        .stall_active (stall != STALL_NONE),
        .wdog_err     (wdog_err)
    );
`else
    logic unused_wdog_limit;
    assign unused_wdog_limit = ^WDOG_LIMIT;
    assign wdog_err          = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: vector table plus reset-during-flush sequence.
module tb_pipe_stall_ctrl;

`ifdef STALL_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif
    localparam int unsigned WLIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        exc_valid, exc_eret;
    logic [31:0] epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cnt;
    logic        wdog_err;

    pipe_stall_ctrl #(
        .EXC_BASE   (32'h0000_0020),
        .WDOG_LIMIT (16'(WLIM))
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .exc_valid    (exc_valid),
        .exc_eret     (exc_eret),
        .epc_i        (epc_i),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_cnt    (stall_cnt),
        .wdog_err     (wdog_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s_if, s_id, s_ex, s_mem, exc, eret;
        logic [31:0] epc;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
    } vec_t;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic        chk_pc;
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        wdog;
    } exp_t;

    vec_t  vecs[$];
    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;

    logic [31:0] m_cnt  = 32'd0;
    int unsigned m_run  = 0;
    logic        m_wdog = 1'b0;

    function automatic vec_t mk(input logic i_f, i_d, i_e, i_m, ex, er,
                                input logic [31:0] epc, input logic [5:0] es,
                                input logic ef, input logic [31:0] ep);
        vec_t v;
        v.s_if = i_f; v.s_id = i_d; v.s_ex = i_e; v.s_mem = i_m;
        v.exc = ex; v.eret = er; v.epc = epc;
        v.e_stall = es; v.e_flush = ef; v.e_pc = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        stallreq_if  = v.s_if;
        stallreq_id  = v.s_id;
        stallreq_ex  = v.s_ex;
        stallreq_mem = v.s_mem;
        exc_valid    = v.exc;
        exc_eret     = v.eret;
        epc_i        = v.epc;
    endtask

    // Drive one cycle at the falling edge, compare just after, then advance the model past the next rising edge.
    task automatic apply(input vec_t v, input string tag);
        exp_t e, got;
        @(negedge clk);
        drive(v);
        e.stall = v.e_stall; e.flush = v.e_flush; e.chk_pc = v.e_flush;
        e.pc = v.e_pc; e.cnt = m_cnt; e.wdog = m_wdog;
        sb.push_back(e);
        #1;
        got = sb.pop_front();
        chk({tag, ".stall"}, 32'(stall), 32'(got.stall));
        chk({tag, ".flush"}, 32'(flush), 32'(got.flush));
        chk({tag, ".stall_cnt"}, stall_cnt, got.cnt);
        chk({tag, ".wdog_err"}, 32'(wdog_err), 32'(got.wdog));
        if (got.chk_pc) chk({tag, ".new_pc"}, new_pc, got.pc);
        if (v.e_stall != 6'd0) m_cnt = m_cnt + 32'd1;
        if (WDOG_ON) begin
            if (v.e_stall != 6'd0) begin
                m_run = (m_run >= WLIM) ? WLIM : m_run + 1;
                if (m_run >= WLIM) m_wdog = 1'b1;
            end else begin
                m_run = 0;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(mk(0,0,0,0,0,0,32'h0,6'h0,0,32'h0));
        #12;
        chk("reset.stall", 32'(stall), 32'h0);
        chk("reset.flush", 32'(flush), 32'h0);
        chk("reset.new_pc", new_pc, 32'h0);
        chk("reset.stall_cnt", stall_cnt, 32'h0);
        chk("reset.wdog_err", 32'(wdog_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        //            if id ex mem exc eret epc          stall      flush new_pc
        vecs.push_back(mk(0,0,0,0, 0,0, 32'h0,        6'b000000, 0, 32'h0));
        vecs.push_back(mk(1,0,0,0, 0,0, 32'h0,        6'b000011, 0, 32'h0));
        vecs.push_back(mk(1,1,0,0, 0,0, 32'h0,        6'b000111, 0, 32'h0));
        vecs.push_back(mk(1,1,0,0, 0,0, 32'h0,        6'b000111, 0, 32'h0));
        vecs.push_back(mk(0,0,0,0, 0,0, 32'h0,        6'b000000, 0, 32'h0));
        vecs.push_back(mk(0,0,1,0, 0,0, 32'h0,        6'b001111, 0, 32'h0));
        vecs.push_back(mk(0,1,1,0, 0,0, 32'h0,        6'b001111, 0, 32'h0));
        vecs.push_back(mk(0,0,1,0, 0,0, 32'h0,        6'b001111, 0, 32'h0));
        vecs.push_back(mk(0,0,0,0, 0,0, 32'h0,        6'b000000, 0, 32'h0));
        vecs.push_back(mk(1,1,1,1, 0,0, 32'h0,        6'b011111, 0, 32'h0));
        vecs.push_back(mk(0,0,0,0, 0,0, 32'h0,        6'b000000, 0, 32'h0));
        // exception with memory stall, held into the flush cycle
        vecs.push_back(mk(0,0,0,1, 1,0, 32'h0,        6'b011111, 0, 32'h0));
        vecs.push_back(mk(0,0,0,1, 1,0, 32'h0,        6'b000000, 1, 32'h20));
        vecs.push_back(mk(0,0,0,0, 0,0, 32'h0,        6'b000000, 0, 32'h0));
        // ERET, held through flush, then back-to-back non-ERET exception
        vecs.push_back(mk(0,0,0,0, 1,1, 32'h1234,     6'b011111, 0, 32'h0));
        vecs.push_back(mk(1,1,1,1, 1,1, 32'h1234,     6'b000000, 1, 32'h1234));
        vecs.push_back(mk(0,0,0,0, 1,0, 32'h5555,     6'b011111, 0, 32'h0));
        vecs.push_back(mk(0,0,0,0, 0,0, 32'h0,        6'b000000, 1, 32'h20));
        vecs.push_back(mk(0,0,0,0, 0,0, 32'h0,        6'b000000, 0, 32'h0));
        // memory stall held long enough to trip the watchdog
        vecs.push_back(mk(0,0,0,1, 0,0, 32'h0,        6'b011111, 0, 32'h0));
        vecs.push_back(mk(0,0,0,1, 0,0, 32'h0,        6'b011111, 0, 32'h0));
        vecs.push_back(mk(0,0,0,1, 0,0, 32'h0,        6'b011111, 0, 32'h0));
        vecs.push_back(mk(0,0,0,1, 0,0, 32'h0,        6'b011111, 0, 32'h0));
        vecs.push_back(mk(0,0,0,0, 0,0, 32'h0,        6'b000000, 0, 32'h0));
        vecs.push_back(mk(0,0,0,0, 0,0, 32'h0,        6'b000000, 0, 32'h0));

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Asynchronous reset asserted in the middle of a flush cycle.
        apply(mk(0,0,0,0, 1,1, 32'hABCD, 6'b011111, 0, 32'h0), "rstx");
        @(negedge clk);
        drive(mk(0,0,0,0,0,0,32'h0,6'h0,0,32'h0));
        #1;
        chk("rstflush.flush_before", 32'(flush), 32'h1);
        chk("rstflush.new_pc_before", new_pc, 32'hABCD);
        #1 rst = 1'b1;
        #1;
        chk("rstflush.flush", 32'(flush), 32'h0);
        chk("rstflush.new_pc", new_pc, 32'h0);
        chk("rstflush.stall_cnt", stall_cnt, 32'h0);
        chk("rstflush.wdog_err", 32'(wdog_err), 32'h0);
        chk("rstflush.stall", 32'(stall), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        m_cnt = 32'd0; m_run = 0; m_wdog = 1'b0;
        apply(mk(1,0,0,0, 0,0, 32'h0, 6'b000011, 0, 32'h0), "post0");
        apply(mk(0,0,0,0, 0,0, 32'h0, 6'b000000, 0, 32'h0), "post1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
